// File: rtl/seg_scan_if.sv
// Signal bundle between the up/down clock's segment encoder and the multiplexed display driver.
// The master side supplies the pattern and controls; the slave side scans them out to the display.
interface seg_scan_if;
  logic [27:0] seg_in;
  logic [3:0]  blank_mask;
  logic [1:0]  bright;
  logic        blink_en;
  logic [6:0]  seg_out;
  logic [3:0]  an_out;
  logic [1:0]  digit_idx;
  logic        frame_start;

  modport master (
    output seg_in, blank_mask, bright, blink_en,
    input  seg_out, an_out, digit_idx, frame_start
  );

  modport slave (
    input  seg_in, blank_mask, bright, blink_en,
    output seg_out, an_out, digit_idx, frame_start
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 4-digit seven-segment driver with per-frame snapshot, blanking,
// brightness windowing and whole-display blink. All display outputs are registered.
module seg_scan_driver #(
  parameter int SCAN_DIV  = 8,
  parameter int BLINK_DIV = 50
) (
  input logic       clk,
  input logic       clr_n,
  seg_scan_if.slave bus
);

  localparam int DW      = $clog2(SCAN_DIV);
  localparam int BW      = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int QUARTER = SCAN_DIV / 4;
  localparam logic [DW-1:0] DIV_LAST   = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [DW-1:0] div_cnt;
  logic [1:0]    digit_q;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;
  logic [27:0]   shadow;
  logic [3:0]    blank_q;
  logic [1:0]    bright_q;
  logic [6:0]    seg_q;
  logic [3:0]    an_q;
  logic          frame_start_q;

  logic          slot_end;
  logic          frame_wrap;
  logic          lit;
  logic [DW:0]   on_limit;
  logic [6:0]    cur_seg;

  // The last clock of every slot stays dark so the next digit never ghosts onto this one.
  always_comb begin
    slot_end   = (div_cnt == DIV_LAST);
    frame_wrap = slot_end && (digit_q == 2'd3);
    on_limit   = (DW+1)'((32'(bright_q) + 32'd1) * 32'(QUARTER));
    cur_seg    = shadow[7*int'(digit_q) +: 7];
    lit        = ({1'b0, div_cnt} < on_limit) && !slot_end &&
                 !blank_q[digit_q] && !(bus.blink_en && blink_phase);
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      div_cnt <= '0;
      digit_q <= '0;
    end else if (slot_end) begin
      div_cnt <= '0;
      digit_q <= digit_q + 2'd1;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  // Inputs are only sampled at the frame wrap so a frame never mixes old and new digits.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      shadow   <= '1;
      blank_q  <= '0;
      bright_q <= '0;
    end else if (frame_wrap) begin
      shadow   <= bus.seg_in;
      blank_q  <= bus.blank_mask;
      bright_q <= bus.bright;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (!bus.blink_en) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_wrap) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      seg_q         <= 7'h7F;
      an_q          <= 4'hF;
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= frame_wrap;
      if (lit) begin
        an_q  <= ~(4'b0001 << digit_q);
        seg_q <= cur_seg;
      end else begin
        an_q  <= 4'hF;
        seg_q <= 7'h7F;
      end
    end
  end

  assign bus.seg_out     = seg_q;
  assign bus.an_out      = an_q;
  assign bus.digit_idx   = digit_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with SCAN_DIV=8, BLINK_DIV=2 (32-clock frames).
// Outputs are sampled on the falling clock edge; inputs are driven there as well.
module tb_seg_scan_driver;

  localparam int SCAN_DIV  = 8;
  localparam int BLINK_DIV = 2;
  localparam logic [27:0] SEG_A    = {7'h79, 7'h24, 7'h30, 7'h40};
  localparam logic [27:0] SEG_B    = {7'h79, 7'h24, 7'h30, 7'h79};
  localparam logic [27:0] SEG_DARK = {4{7'h7F}};

  logic clk = 1'b0;
  logic clr_n = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   slot_lows[4];

  seg_scan_if bus ();

  seg_scan_driver #(.SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Walks one frame starting from a cycle whose state is digit 0, div 0. Output at step k
  // reflects the counter state k-1 clocks in; chg_k lets a scenario change inputs mid-frame.
  task automatic check_frame(input string name, input logic [27:0] seg, input logic [3:0] mask,
                             input int br, input int dark_until, input int chg_k,
                             input logic [27:0] chg_seg, input logic chg_blink);
    for (int s = 0; s < 4; s++) slot_lows[s] = 0;
    for (int k = 1; k <= 32; k++) begin
      int sl, d;
      logic lit;
      logic [3:0] ea;
      logic [6:0] es;
      logic [1:0] ei;
      logic ef;
      @(negedge clk);
      sl  = (k - 1) / 8;
      d   = (k - 1) % 8;
      lit = (k > dark_until) && (d < (br + 1) * 2) && (d != 7) && !mask[sl];
      ea  = lit ? ~(4'b0001 << sl) : 4'hF;
      es  = lit ? seg[7*sl +: 7] : 7'h7F;
      ei  = 2'((k / 8) % 4);
      ef  = (k == 32);
      if (bus.an_out[sl] == 1'b0) slot_lows[sl]++;
      checks++;
      if (bus.an_out !== ea) begin
        failures++;
        $display("[TB] FAIL %s an_out k=%0d: got %b expected %b", name, k, bus.an_out, ea);
      end
      checks++;
      if (bus.seg_out !== es) begin
        failures++;
        $display("[TB] FAIL %s seg_out k=%0d: got %h expected %h", name, k, bus.seg_out, es);
      end
      checks++;
      if (bus.digit_idx !== ei) begin
        failures++;
        $display("[TB] FAIL %s digit_idx k=%0d: got %0d expected %0d", name, k, bus.digit_idx, ei);
      end
      checks++;
      if (bus.frame_start !== ef) begin
        failures++;
        $display("[TB] FAIL %s frame_start k=%0d: got %b expected %b", name, k, bus.frame_start, ef);
      end
      if (k == chg_k) begin
        bus.seg_in   = chg_seg;
        bus.blink_en = chg_blink;
      end
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (bus.an_out !== 4'hF || bus.seg_out !== 7'h7F) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got an=%b seg=%h expected an=1111 seg=7f", bus.an_out, bus.seg_out);
    end
    checks++;
    if (bus.digit_idx !== 2'd0 || bus.frame_start !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_state: got idx=%0d fs=%b expected idx=0 fs=0", bus.digit_idx, bus.frame_start);
    end
    @(negedge clk);
    @(negedge clk);
    clr_n = 1'b1;
    check_frame("reset_frame1", SEG_DARK, 4'h0, 0, 0, 0, SEG_A, 1'b0);
  endtask

  task automatic test_scan();
    int vk[8];
    logic [3:0] van[8];
    logic [6:0] vseg[8];
    int j;
    vk   = '{1, 7, 8, 9, 17, 25, 31, 32};
    van  = '{4'b1110, 4'b1110, 4'b1111, 4'b1101, 4'b1011, 4'b0111, 4'b0111, 4'b1111};
    vseg = '{7'h40, 7'h40, 7'h7F, 7'h30, 7'h24, 7'h79, 7'h79, 7'h7F};
    j = 0;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      if (j < 8 && k == vk[j]) begin
        checks++;
        if (bus.an_out !== van[j] || bus.seg_out !== vseg[j]) begin
          failures++;
          $display("[TB] FAIL scan_vector k=%0d: got an=%b seg=%h expected an=%b seg=%h",
                   k, bus.an_out, bus.seg_out, van[j], vseg[j]);
        end
        j++;
      end
    end
  endtask

  task automatic test_bright();
    int exp_lows[3];
    int prev;
    exp_lows = '{2, 4, 6};
    prev = 3;
    for (int b = 0; b < 3; b++) begin
      bus.bright = 2'(b);
      check_frame("bright_prev", SEG_A, 4'h0, prev, 0, 0, SEG_A, 1'b0);
      check_frame("bright_new", SEG_A, 4'h0, b, 0, 0, SEG_A, 1'b0);
      for (int s = 0; s < 4; s++) begin
        checks++;
        if (slot_lows[s] !== exp_lows[b]) begin
          failures++;
          $display("[TB] FAIL bright%0d_lows slot=%0d: got %0d expected %0d", b, s, slot_lows[s], exp_lows[b]);
        end
      end
      prev = b;
    end
    bus.bright = 2'd3;
    check_frame("bright_restore", SEG_A, 4'h0, prev, 0, 0, SEG_A, 1'b0);
  endtask

  task automatic test_shadow();
    check_frame("shadow_old", SEG_A, 4'h0, 3, 0, 10, SEG_B, 1'b0);
    check_frame("shadow_new", SEG_B, 4'h0, 3, 0, 0, SEG_B, 1'b0);
  endtask

  task automatic test_blank();
    bus.blank_mask = 4'b1000;
    check_frame("blank_prev", SEG_B, 4'h0, 3, 0, 0, SEG_B, 1'b0);
    check_frame("blank_on", SEG_B, 4'b1000, 3, 0, 0, SEG_B, 1'b0);
    checks++;
    if (slot_lows[3] !== 0 || slot_lows[0] !== 7) begin
      failures++;
      $display("[TB] FAIL blank_lows: got slot3=%0d slot0=%0d expected slot3=0 slot0=7", slot_lows[3], slot_lows[0]);
    end
    bus.blank_mask = 4'h0;
    check_frame("blank_release", SEG_B, 4'b1000, 3, 0, 0, SEG_B, 1'b0);
  endtask

  task automatic test_blink();
    bus.blink_en = 1'b1;
    check_frame("blink_lit_a", SEG_B, 4'h0, 3, 0, 0, SEG_B, 1'b1);
    check_frame("blink_lit_b", SEG_B, 4'h0, 3, 0, 0, SEG_B, 1'b1);
    check_frame("blink_dark_c", SEG_B, 4'h0, 3, 32, 0, SEG_B, 1'b1);
    check_frame("blink_dark_d", SEG_B, 4'h0, 3, 32, 0, SEG_B, 1'b1);
    check_frame("blink_lit_e", SEG_B, 4'h0, 3, 0, 0, SEG_B, 1'b1);
    check_frame("blink_lit_f", SEG_B, 4'h0, 3, 0, 0, SEG_B, 1'b1);
    check_frame("blink_release", SEG_B, 4'h0, 3, 12, 12, SEG_B, 1'b0);
    check_frame("blink_off", SEG_B, 4'h0, 3, 0, 0, SEG_B, 1'b0);
  endtask

  task automatic test_mid_reset();
    for (int k = 1; k <= 19; k++) @(negedge clk);
    checks++;
    if (bus.digit_idx !== 2'd2) begin
      failures++;
      $display("[TB] FAIL midreset_pre idx: got %0d expected 2", bus.digit_idx);
    end
    clr_n = 1'b0;
    #1;
    checks++;
    if (bus.an_out !== 4'hF || bus.seg_out !== 7'h7F) begin
      failures++;
      $display("[TB] FAIL midreset_outputs: got an=%b seg=%h expected an=1111 seg=7f", bus.an_out, bus.seg_out);
    end
    checks++;
    if (bus.digit_idx !== 2'd0 || bus.frame_start !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midreset_state: got idx=%0d fs=%b expected idx=0 fs=0", bus.digit_idx, bus.frame_start);
    end
    @(negedge clk);
    @(negedge clk);
    clr_n = 1'b1;
    check_frame("midreset_frame1", SEG_DARK, 4'h0, 0, 0, 0, SEG_B, 1'b0);
  endtask

  initial begin
    bus.seg_in     = SEG_A;
    bus.blank_mask = 4'h0;
    bus.bright     = 2'd3;
    bus.blink_en   = 1'b0;
    #1 clr_n = 1'b0;
    test_reset();
    test_scan();
    test_bright();
    test_shadow();
    test_blank();
    test_blink();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Downstream display stage for the up/down clock.
- Takes the clock's 4-digit, 28-bit active-low seven-segment pattern and drives one shared 7-bit segment bus plus 4 active-low digit anodes, time-multiplexed.
- Adds a tear-free frame snapshot, per-digit blanking, 4-level brightness and whole-display blink.

Parameters:
- SCAN_DIV, 8: clocks per digit slot; integer ≥4, multiple of 4.
- BLINK_DIV, 50: frames per blink half-period; ≥1.

Ports:
- clk  in  1  system clock.
- clr_n  in  1  reset; asynchronous, active-low.
- seg_in  in  28  digit i pattern at [7i+:7], active-low (0 = segment on).
- blank_mask  in  4  1 = force digit i dark.
- bright  in  2  brightness; on-window = (bright+1)*SCAN_DIV/4 clocks per slot.
- blink_en  in  1  1 = blink whole display.
- seg_out  out  7  active-low segment bus.
- an_out  out  4  active-low one-cold anode select.
- digit_idx  out  2  current slot index.
- frame_start  out  1  one-cycle pulse at each frame wrap.

Behaviour:
- Reset: clr_n low clears state immediately, with no clock needed.
  - div_cnt=0, digit_idx=0, blink_cnt=0, blink_phase=0.
  - shadow=all 7'h7F; blank_q=0; bright_q=0.
  - seg_out=7'h7F, an_out=4'hF, frame_start=0.
- Slot counter: div_cnt increments every clock over 0..SCAN_DIV-1.
  - At SCAN_DIV-1 it wraps to 0 and digit_idx increments mod 4.
- Frame = 4 slots = 4*SCAN_DIV clocks.
- Frame wrap: the edge where div_cnt=SCAN_DIV-1 and digit_idx=3. On that edge:
  - shadow<=seg_in, blank_q<=blank_mask, bright_q<=bright.
  - blink update runs (see Blink).
  - frame_start<=1 for exactly one cycle, coincident with digit_idx=0, div_cnt=0.
  - Not asserted in the post-reset state.
- Input changes between wraps have no visible effect until the next wrap.
- Blink:
  - blink_en=0: blink_cnt and blink_phase are held at 0 on every edge.
  - blink_en=1: at each frame wrap, blink_cnt increments. When blink_cnt=BLINK_DIV-1 it wraps to 0 and blink_phase toggles.
  - Visible while blink_phase=0.
- Lit condition, evaluated on current state:
  - div_cnt < (bright_q+1)*SCAN_DIV/4,
  - AND div_cnt ≠ SCAN_DIV-1 (anti-ghost dead cycle, always dark),
  - AND blank_q[digit_idx]=0,
  - AND NOT (blink_en AND blink_phase).
- Outputs are registered with 1-cycle latency from counter state:
  - Lit: an_out<=~(4'b1<<digit_idx), seg_out<=shadow[7*digit_idx+:7].
  - Not lit: an_out<=4'hF, seg_out<=7'h7F.
- At most one anode is low in any cycle. seg_out=7'h7F whenever an_out=4'hF.
- First frame after reset shows the reset shadow: anodes cycle, segments stay 7'h7F.
- bright=3 gives SCAN_DIV-1 lit clocks per slot (dead cycle wins).
- clr_n asserted mid-slot aborts the scan at once. Release restarts at digit 0, div_cnt 0.
- digit_idx output equals the internal counter (unregistered view).

Test Plan (SCAN_DIV=8, BLINK_DIV=2; frame = 32 clocks):
- Reset with seg_in={7'h79,7'h24,7'h30,7'h40}, bright=3, mask=0, blink_en=0:
  - Frame 1: seg_out stays 7'h7F.
  - From frame 2, one cycle after frame_start: an_out=4'b1110 with seg_out=7'h40 for 7 clocks, 1 dark clock, then 4'b1101/7'h30, and so on.
- bright=0 latched: each anode low exactly 2 clocks per 8-clock slot. bright=1 → 4, bright=2 → 6.
- Change seg_in[6:0] 7'h40→7'h79 at digit_idx=1: digit 0 still shows 7'h40 for the rest of the frame; 7'h79 appears in the slot after the next frame_start.
- blank_mask=4'b1000: during slot 3, an_out=4'hF and seg_out=7'h7F for all 8 clocks; digits 0–2 unaffected.
- blink_en=1 from a frame boundary: 2 frames lit, 2 frames fully dark, repeating. Deassert blink_en while dark: lit again within 1 clock of the next lit-condition cycle.
- Pull clr_n low at div_cnt=3, digit_idx=2:
  - Same instant: an_out=4'hF, seg_out=7'h7F, digit_idx=0.
  - After release: frame 1 segments dark, no frame_start until the 32nd edge.
